ex_stage_mc: RTL
================

# ex_stage_mc

Parametrised execute stage for the in-order pipeline, replacing the fixed 16-bit single-cycle execute stage. It owns the ID/EX pipeline register, the two forwarding muxes, the ALU, a comparator and the EX/MEM output register. It adds a multi-cycle multiply/divide unit with HI/LO registers and a stall handshake. It sits between decode (ID) and memory (MEM), and the hazard unit drives its forwarding selects.

## Interface
Parameters:
- WIDTH, 16: datapath width; must be ≥ 8 and a power of 2.
- RA_W, 4: register-address width.
- MUL_CYCLES, 2: multiply latency in EX cycles; must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock.
- rest  in  1  reset, synchronous, active-high.
- freeze_in  in  1  hold ID/EX contents (load-use stall from hazard unit).
- flush_in  in  1  load a bubble into ID/EX; has priority over freeze_in.
- valid_in  in  1  decode slot holds a real instruction.
- op_in  in  4  operation code (encoding under Operation).
- src1_in, src2_in  in  WIDTH  decoded operands.
- store_in  in  WIDTH  store data, passed through.
- rd_in  in  RA_W  destination register.
- fwd_a_sel, fwd_b_sel  in  2  operand select: 0 = ID/EX, 1 = MEM/WB data, 2 = EX/MEM data, 3 = ID/EX.
- exmem_data, memwb_data  in  WIDTH  forwarding sources.
- stall_out  out  1  multi-cycle op in progress; upstream must freeze.
- valid_out  out  1  EX/MEM slot valid.
- result_out  out  WIDTH  registered result.
- store_out  out  WIDTH  registered store data.
- rd_out  out  RA_W  registered destination.
- compare_flag  out  1  combinational: forwarded A == forwarded B.
- hi_out, lo_out  out  WIDTH  HI/LO registers.
- sr_out  out  4  registered flags {V,C,N,Z}.

## Operation
- op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA; shift amount is B[log2(WIDTH)-1:0].
  - 9 SLT (signed; result is 1 or 0).
  - 10 MUL (unsigned): {HI,LO} = A*B.
  - 11 DIVU: LO = A/B, HI = A%B.
  - 12 MFHI, 13 MFLO; 14–15 NOP (result 0).
- Flags:
  - Z and N are updated by every valid single-cycle op.
  - C and V are updated only by ADD and SUB.
  - SUB's C is the not-borrow.
  - MUL and DIVU leave all flags unchanged, except that divide-by-zero sets V.
- Divide-by-zero: LO = all ones, HI = A; the op completes in 1 EX cycle.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL on a valid op 10; IDLE → DIV on a valid op 11 with B ≠ 0.
  - On entry the forwarded A and B are latched into internal operand registers, so later forwarding changes do not affect the op.
  - MUL counts MUL_CYCLES−1 further cycles.
  - DIV is a restoring divider, one quotient bit per cycle, WIDTH cycles.
  - On the last cycle HI/LO are written and the FSM returns to IDLE.
- stall_out = (state != IDLE). While stall_out is high:
  - ID/EX holds.
  - valid_out is 0 (bubbles are emitted).
- When the op completes, the EX/MEM slot receives rd with valid = 1 and result = LO. This lets MUL/DIVU write the low word to the GPR.
- ID/EX update rule, in priority order: rest → all zero; flush_in → valid 0; freeze_in or stall_out → hold; otherwise load.
- An invalid ID/EX slot produces valid_out = 0 and does not touch flags, HI/LO or the FSM.

## Timing
- Reset values: all ID/EX and EX/MEM fields 0, valid_out 0, result_out 0, store_out 0, rd_out 0, hi_out 0, lo_out 0, sr_out 0, FSM in IDLE, stall_out 0.
- Single-cycle op: accepted into ID/EX on edge N, visible on result_out after edge N+1 (latency 2).
- MUL accepted at edge N:
  - stall_out is high during cycles N+1 … N+MUL_CYCLES−1.
  - result_out, hi_out and lo_out update at edge N+MUL_CYCLES.
  - With MUL_CYCLES = 1 there is no stall.
- DIVU: stall_out is high for WIDTH−1 cycles; the result is ready at edge N+WIDTH.
- MFHI/MFLO immediately after MUL/DIVU read the updated HI/LO; in-order issue plus the stall guarantees this.
- rest mid-operation aborts the FSM. HI/LO are forced to 0, and stall_out drops the next cycle.
- flush_in during a stall:
  - Clears the slot that is holding behind the stall.
  - Does not abort the running multi-cycle op.

## Structure
- Shared package ex_pkg holds:
  - op-code localparams (OP_ADD … OP_NOP);
  - forwarding select constants (FWD_IDEX, FWD_MEMWB, FWD_EXMEM);
  - flag bit indices (SR_Z, SR_N, SR_C, SR_V).
- Sub-module muldiv_unit (parameters WIDTH, MUL_CYCLES) contains the FSM, the operand latches, the iterative divider and HI/LO. It exposes start, op, a, b, busy, done, hi and lo.
- The ALU, forwarding muxes and pipeline registers stay in ex_stage_mc.

## Test plan
- Reset, then ADD 0x7FFF + 0x0001 (WIDTH = 16) → result_out 0x8000, sr_out V=1, N=1, Z=0, C=0, at latency 2.
- Forwarding: fwd_a_sel = 2 with exmem_data = 0x0010, src2 = 0x0003, op SUB → result 0x000D; the same op with fwd_a_sel = 1 and memwb_data = 0x0002 → result 0xFFFF with C = 0.
- MUL 0x1234 × 0x0100 with MUL_CYCLES = 2 → stall_out high for exactly 1 cycle, HI = 0x0012, LO = 0x3400; a following MFHI returns 0x0012.
- DIVU 100 / 7 → stall_out high for 15 cycles, LO = 14, HI = 2. DIVU 5 / 0 → no stall, LO = 0xFFFF, HI = 5, V = 1.
- rest asserted in DIV cycle 5 → the next cycle shows stall_out 0, hi_out and lo_out 0, valid_out 0; an ADD issued afterwards completes normally.
- freeze_in and flush_in asserted in the same cycle → bubble loaded (valid_out 0 two cycles later).

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: op codes, forwarding selects,
// status-register bit positions and the multiply/divide FSM state type.
package ex_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12;
  localparam logic [3:0] OP_MFLO = 4'd13;
  localparam logic [3:0] OP_NOP  = 4'd14;

  localparam logic [1:0] FWD_IDEX  = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

  localparam int SR_Z = 0;
  localparam int SR_N = 1;
  localparam int SR_C = 2;
  localparam int SR_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply and restoring divide with HI/LO registers.
// done is combinational: it marks the cycle whose closing edge writes HI/LO,
// and lo_next carries the LO value written at that edge.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] lo_next
);

  localparam int CNT_W = $clog2(WIDTH + MUL_CYCLES) + 1;

  md_state_t          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, rem_q, hi_q, lo_q;

  logic               is_idle, go_mul, go_div, div_zero, last_mul, last_div, ge;
  logic [WIDTH-1:0]   mul_a, mul_b, div_rem_in, div_quo_in, div_b, rem_new, quo_new;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem_sh, diff;

  // Operand selection, product and one restoring-divide step; in IDLE the
  // live operands are used so the first step happens on the entry edge.
  always_comb begin
    is_idle    = (state_q == IDLE);
    go_mul     = is_idle && start && (op == OP_MUL);
    go_div     = is_idle && start && (op == OP_DIVU);
    div_zero   = go_div && (b == '0);
    mul_a      = is_idle ? a : a_q;
    mul_b      = is_idle ? b : b_q;
    prod       = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
    div_rem_in = is_idle ? '0 : rem_q;
    div_quo_in = is_idle ? a : a_q;
    div_b      = is_idle ? b : b_q;
    rem_sh     = {div_rem_in, div_quo_in[WIDTH-1]};
    diff       = rem_sh - {1'b0, div_b};
    ge         = ~diff[WIDTH];
    rem_new    = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_new    = {div_quo_in[WIDTH-2:0], ge};
    last_mul   = ((state_q == MUL) && (cnt_q == CNT_W'(1))) ||
                 (go_mul && (MUL_CYCLES == 1));
    last_div   = (state_q == DIV) && (cnt_q == CNT_W'(1));
    done       = last_mul || last_div || div_zero;
    if (div_zero)      lo_next = '1;
    else if (last_div) lo_next = quo_new;
    else               lo_next = prod[WIDTH-1:0];
  end

  // Control FSM with operand latches, divider state and HI/LO.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_zero) begin
            hi_q <= a;
            lo_q <= '1;
          end else if (go_div) begin
            state_q <= DIV;
            cnt_q   <= CNT_W'(WIDTH - 1);
            a_q     <= quo_new;
            b_q     <= b;
            rem_q   <= rem_new;
          end else if (go_mul) begin
            if (last_mul) begin
              hi_q <= prod[2*WIDTH-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end else begin
              state_q <= MUL;
              cnt_q   <= CNT_W'(MUL_CYCLES - 1);
              a_q     <= a;
              b_q     <= b;
            end
          end
        end
        MUL: begin
          if (last_mul) begin
            hi_q    <= prod[2*WIDTH-1:WIDTH];
            lo_q    <= prod[WIDTH-1:0];
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DIV: begin
          a_q   <= quo_new;
          rem_q <= rem_new;
          if (last_div) begin
            hi_q    <= rem_new;
            lo_q    <= quo_new;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: ID/EX register, forwarding muxes, ALU, comparator,
// EX/MEM register and the multi-cycle multiply/divide unit.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int RA_W       = 4,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             freeze_in,
  input  logic             flush_in,
  input  logic             valid_in,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] src1_in,
  input  logic [WIDTH-1:0] src2_in,
  input  logic [WIDTH-1:0] store_in,
  input  logic [RA_W-1:0]  rd_in,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic [WIDTH-1:0] memwb_data,
  output logic             stall_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] store_out,
  output logic [RA_W-1:0]  rd_out,
  output logic             compare_flag,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [3:0]       sr_out
);

  localparam int SH_W = $clog2(WIDTH);

  logic             idex_valid_q, idex_valid_d;
  logic [3:0]       idex_op_q, idex_op_d;
  logic [WIDTH-1:0] idex_src1_q, idex_src1_d, idex_src2_q, idex_src2_d;
  logic [WIDTH-1:0] idex_store_q, idex_store_d;
  logic [RA_W-1:0]  idex_rd_q, idex_rd_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d, store_q, store_d;
  logic [RA_W-1:0]  rd_q, rd_d, mdrd_q, mdrd_d;
  logic [3:0]       sr_q, sr_d;

  logic [WIDTH-1:0] op_a, op_b, alu_res, md_hi, md_lo, md_lo_next;
  logic [WIDTH:0]   sum, diff;
  logic             c_new, v_new, flag_cv;
  logic             md_busy, md_done, ex_fire, md_start, div_zero;

  // ID/EX next state: flush beats freeze/stall, which beat a normal load.
  always_comb begin
    idex_valid_d = idex_valid_q;
    idex_op_d    = idex_op_q;
    idex_src1_d  = idex_src1_q;
    idex_src2_d  = idex_src2_q;
    idex_store_d = idex_store_q;
    idex_rd_d    = idex_rd_q;
    if (flush_in) begin
      idex_valid_d = 1'b0;
    end else if (!(freeze_in || md_busy)) begin
      idex_valid_d = valid_in;
      idex_op_d    = op_in;
      idex_src1_d  = src1_in;
      idex_src2_d  = src2_in;
      idex_store_d = store_in;
      idex_rd_d    = rd_in;
    end
  end

  // Forwarding muxes; select 3 falls back to the ID/EX operand.
  always_comb begin
    case (fwd_a_sel)
      FWD_MEMWB: op_a = memwb_data;
      FWD_EXMEM: op_a = exmem_data;
      default:   op_a = idex_src1_q;
    endcase
    case (fwd_b_sel)
      FWD_MEMWB: op_b = memwb_data;
      FWD_EXMEM: op_b = exmem_data;
      default:   op_b = idex_src2_q;
    endcase
  end

  // Single-cycle ALU; carry/overflow only produced by ADD and SUB.
  always_comb begin
    alu_res = '0;
    c_new   = 1'b0;
    v_new   = 1'b0;
    flag_cv = 1'b0;
    sum     = {1'b0, op_a} + {1'b0, op_b};
    diff    = {1'b0, op_a} - {1'b0, op_b};
    case (idex_op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        c_new   = sum[WIDTH];
        v_new   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        flag_cv = 1'b1;
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        c_new   = ~diff[WIDTH];
        v_new   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        flag_cv = 1'b1;
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLL:  alu_res = op_a << op_b[SH_W-1:0];
      OP_SRL:  alu_res = op_a >> op_b[SH_W-1:0];
      OP_SRA:  alu_res = $signed(op_a) >>> op_b[SH_W-1:0];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_MFHI: alu_res = md_hi;
      OP_MFLO: alu_res = md_lo;
      default: alu_res = '0;
    endcase
  end

  assign ex_fire  = idex_valid_q && !md_busy;
  assign md_start = ex_fire && ((idex_op_q == OP_MUL) || (idex_op_q == OP_DIVU));
  assign div_zero = md_start && (idex_op_q == OP_DIVU) && (op_b == '0);

  muldiv_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_muldiv (
    .clk     (clk),
    .rest    (rest),
    .start   (md_start),
    .op      (idex_op_q),
    .a       (op_a),
    .b       (op_b),
    .busy    (md_busy),
    .done    (md_done),
    .hi      (md_hi),
    .lo      (md_lo),
    .lo_next (md_lo_next)
  );

  // EX/MEM next state and flags; a finishing mul/div owns the slot.
  always_comb begin
    valid_d  = 1'b0;
    result_d = '0;
    store_d  = '0;
    rd_d     = '0;
    sr_d     = sr_q;
    mdrd_d   = md_start ? idex_rd_q : mdrd_q;
    if (md_done) begin
      valid_d  = 1'b1;
      result_d = md_lo_next;
      rd_d     = md_busy ? mdrd_q : idex_rd_q;
    end else if (ex_fire && !md_start) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      store_d  = idex_store_q;
      rd_d     = idex_rd_q;
    end
    if (ex_fire && !md_start) begin
      sr_d[SR_Z] = (alu_res == '0);
      sr_d[SR_N] = alu_res[WIDTH-1];
      if (flag_cv) begin
        sr_d[SR_C] = c_new;
        sr_d[SR_V] = v_new;
      end
    end
    if (div_zero) sr_d[SR_V] = 1'b1;
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rest) begin
      idex_valid_q <= 1'b0;
      idex_op_q    <= '0;
      idex_src1_q  <= '0;
      idex_src2_q  <= '0;
      idex_store_q <= '0;
      idex_rd_q    <= '0;
      valid_q      <= 1'b0;
      result_q     <= '0;
      store_q      <= '0;
      rd_q         <= '0;
      mdrd_q       <= '0;
      sr_q         <= '0;
    end else begin
      idex_valid_q <= idex_valid_d;
      idex_op_q    <= idex_op_d;
      idex_src1_q  <= idex_src1_d;
      idex_src2_q  <= idex_src2_d;
      idex_store_q <= idex_store_d;
      idex_rd_q    <= idex_rd_d;
      valid_q      <= valid_d;
      result_q     <= result_d;
      store_q      <= store_d;
      rd_q         <= rd_d;
      mdrd_q       <= mdrd_d;
      sr_q         <= sr_d;
    end
  end

  assign stall_out    = md_busy;
  assign valid_out    = valid_q;
  assign result_out   = result_q;
  assign store_out    = store_q;
  assign rd_out       = rd_q;
  assign compare_flag = (op_a == op_b);
  assign hi_out       = md_hi;
  assign lo_out       = md_lo;
  assign sr_out       = sr_q;

endmodule
